// File: rtl/lnrv_wbck_pkg.sv
// lnrv_wbck_pkg: shared widths and write-back source encodings
package lnrv_wbck_pkg;
  localparam int CPU_DATA_WIDTH = 32;
  localparam int GPR_ADDR_WIDTH = 5;
  typedef enum logic [1:0] {WB_SRC_NONE, WB_SRC_ALU, WB_SRC_LSU, WB_SRC_MDU} wb_src_e;
endpackage

// File: rtl/lnrv_rr_arb2.sv
// lnrv_rr_arb2: two-requester round-robin arbiter, pointer advances only past a granted requester
module lnrv_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] rdy
);
  logic ptr;
  // each side sees only the other's request, so a ready never depends on its own valid
  always_comb begin
    rdy[0] = en & (!ptr | !req[1]);
    rdy[1] = en & (ptr | !req[0]);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr <= 1'b0;
    else if (rdy[0] & req[0]) ptr <= 1'b1;
    else if (rdy[1] & req[1]) ptr <= 1'b0;
endmodule

// File: rtl/lnrv_wbck.sv
// lnrv_wbck: merges ALU/LSU/MDU results into one registered GPR write and tracks pending long writes
module lnrv_wbck
  import lnrv_wbck_pkg::*;
#(
  parameter int P_ADDR_WIDTH = GPR_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_vld,
  output logic                      alu_rdy,
  input  logic [P_ADDR_WIDTH-1:0]   alu_idx,
  input  logic [CPU_DATA_WIDTH-1:0] alu_data,
  input  logic                      lsu_vld,
  output logic                      lsu_rdy,
  input  logic [P_ADDR_WIDTH-1:0]   lsu_idx,
  input  logic [CPU_DATA_WIDTH-1:0] lsu_data,
  input  logic                      mdu_vld,
  output logic                      mdu_rdy,
  input  logic [P_ADDR_WIDTH-1:0]   mdu_idx,
  input  logic [CPU_DATA_WIDTH-1:0] mdu_data,
  output logic                      wr_vld,
  input  logic                      wr_rdy,
  output logic [P_ADDR_WIDTH-1:0]   wr_idx,
  output logic [CPU_DATA_WIDTH-1:0] wr_data,
  input  logic                      disp_vld,
  input  logic                      disp_long,
  input  logic [P_ADDR_WIDTH-1:0]   disp_rd_idx,
  input  logic [P_ADDR_WIDTH-1:0]   rs1_idx,
  input  logic [P_ADDR_WIDTH-1:0]   rs2_idx,
  output logic                      rs1_busy,
  output logic                      rs2_busy
);
  localparam int N = 1 << P_ADDR_WIDTH;
  logic                      load_en;
  logic                      load;
  logic [1:0]                rr_rdy;
  wb_src_e                   src;
  logic [P_ADDR_WIDTH-1:0]   sel_idx;
  logic [CPU_DATA_WIDTH-1:0] sel_data;
  logic [N-1:0]              sb;
  logic [N-1:0]              sb_set;
  logic [N-1:0]              sb_clr;
  assign load_en = !wr_vld | wr_rdy;
  lnrv_rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (load_en & !alu_vld),
    .req     ({mdu_vld, lsu_vld}),
    .rdy     (rr_rdy)
  );
  always_comb begin
    alu_rdy  = load_en;
    lsu_rdy  = rr_rdy[0];
    mdu_rdy  = rr_rdy[1];
    src      = (alu_vld & load_en) ? WB_SRC_ALU :
               (lsu_vld & rr_rdy[0]) ? WB_SRC_LSU :
               (mdu_vld & rr_rdy[1]) ? WB_SRC_MDU : WB_SRC_NONE;
    sel_idx  = src == WB_SRC_LSU ? lsu_idx : src == WB_SRC_MDU ? mdu_idx : alu_idx;
    sel_data = src == WB_SRC_LSU ? lsu_data : src == WB_SRC_MDU ? mdu_data : alu_data;
    // x0 results are acknowledged but never reach the GPR port
    load     = (src != WB_SRC_NONE) && (sel_idx != '0);
    sb_set   = (disp_vld & disp_long & (disp_rd_idx != '0)) ? N'(1) << disp_rd_idx : '0;
    sb_clr   = (wr_vld & wr_rdy) ? N'(1) << wr_idx : '0;
    rs1_busy = (rs1_idx != '0) & (sb[rs1_idx] | (wr_vld & (wr_idx == rs1_idx)));
    rs2_busy = (rs2_idx != '0) & (sb[rs2_idx] | (wr_vld & (wr_idx == rs2_idx)));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_vld  <= 1'b0;
      wr_idx  <= '0;
      wr_data <= '0;
    end else if (load_en) begin
      wr_vld <= load;
      if (load) begin
        wr_idx  <= sel_idx;
        wr_data <= sel_data;
      end
    end
  // set after clear so a fresh dispatch outlives the retiring older write
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sb <= '0;
    else sb <= ((sb & ~sb_clr) | sb_set) & ~N'(1);
endmodule

// File: tb/tb_lnrv_wbck.sv
// tb_lnrv_wbck: vector table plus directed sequences, GPR writes checked against an expected-write queue
module tb_lnrv_wbck;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_vld = 1'b0, lsu_vld = 1'b0, mdu_vld = 1'b0;
  logic        alu_rdy, lsu_rdy, mdu_rdy;
  logic [4:0]  alu_idx = '0, lsu_idx = '0, mdu_idx = '0;
  logic [31:0] alu_data = '0, lsu_data = '0, mdu_data = '0;
  logic        wr_vld, wr_rdy = 1'b1;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        disp_vld = 1'b0, disp_long = 1'b0;
  logic [4:0]  disp_rd_idx = '0, rs1_idx = '0, rs2_idx = '0;
  logic        rs1_busy, rs2_busy;
  int checks = 0;
  int fails = 0;
  typedef struct packed {logic [4:0] idx; logic [31:0] data;} wb_t;
  wb_t q[$];
  typedef struct {logic a, l, m; logic [4:0] ai, li, mi; logic [2:0] eg;} vec_t;
  vec_t tbl[12];
  always #5 clk = ~clk;
  lnrv_wbck dut (
    .clk(clk), .reset_n(reset_n),
    .alu_vld(alu_vld), .alu_rdy(alu_rdy), .alu_idx(alu_idx), .alu_data(alu_data),
    .lsu_vld(lsu_vld), .lsu_rdy(lsu_rdy), .lsu_idx(lsu_idx), .lsu_data(lsu_data),
    .mdu_vld(mdu_vld), .mdu_rdy(mdu_rdy), .mdu_idx(mdu_idx), .mdu_data(mdu_data),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_idx(wr_idx), .wr_data(wr_data),
    .disp_vld(disp_vld), .disp_long(disp_long), .disp_rd_idx(disp_rd_idx),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // mid-cycle: retire the current write against the queue, check the source handshake, queue what it will write
  task automatic tick(input logic [2:0] eg);
    wb_t e;
    @(negedge clk);
    if (wr_vld && wr_rdy) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got idx %0h, none expected", wr_idx);
      end else begin
        e = q.pop_front();
        chk("wr_idx", 32'(wr_idx), 32'(e.idx));
        chk("wr_data", wr_data, e.data);
      end
    end
    chk("grant", {29'd0, alu_vld & alu_rdy, lsu_vld & lsu_rdy, mdu_vld & mdu_rdy}, {29'd0, eg});
    if (eg[2] && alu_idx != 0) q.push_back({alu_idx, alu_data});
    else if (eg[1] && lsu_idx != 0) q.push_back({lsu_idx, lsu_data});
    else if (eg[0] && mdu_idx != 0) q.push_back({mdu_idx, mdu_data});
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{1, 0, 0, 5, 0, 0, 3'b100};
    tbl[1]  = '{0, 1, 1, 0, 1, 2, 3'b010};
    tbl[2]  = '{0, 1, 1, 0, 3, 4, 3'b001};
    tbl[3]  = '{1, 1, 1, 6, 8, 9, 3'b100};
    tbl[4]  = '{0, 1, 1, 0, 8, 9, 3'b010};
    tbl[5]  = '{0, 1, 1, 0, 11, 12, 3'b001};
    tbl[6]  = '{0, 0, 1, 0, 0, 13, 3'b001};
    tbl[7]  = '{0, 1, 0, 0, 14, 0, 3'b010};
    tbl[8]  = '{0, 1, 0, 0, 15, 0, 3'b010};
    tbl[9]  = '{0, 0, 1, 0, 0, 0, 3'b001};
    tbl[10] = '{0, 1, 1, 0, 16, 17, 3'b010};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 3'b000};
    rs1_idx = 5'd3;
    #2;
    chk("rst_wr_vld", 32'(wr_vld), 0);
    chk("rst_wr_idx", 32'(wr_idx), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", 32'(rs1_busy), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    alu_vld = 1'b1; alu_idx = 5'd5; alu_data = 32'h1234;
    tick(3'b100);
    chk("lat_wr_vld", 32'(wr_vld), 1);
    chk("lat_wr_idx", 32'(wr_idx), 5);
    chk("lat_wr_data", wr_data, 32'h1234);
    alu_vld = 1'b0;
    tick(3'b000);
    for (int i = 0; i < 12; i++) begin
      alu_vld = tbl[i].a; alu_idx = tbl[i].ai; alu_data = 32'hA000_0000 + i;
      lsu_vld = tbl[i].l; lsu_idx = tbl[i].li; lsu_data = 32'hB000_0000 + i;
      mdu_vld = tbl[i].m; mdu_idx = tbl[i].mi; mdu_data = 32'hC000_0000 + i;
      tick(tbl[i].eg);
    end
    chk("table_drained", q.size(), 0);
    alu_vld = 1'b1; alu_idx = 5'd7; alu_data = 32'h77;
    tick(3'b100);
    wr_rdy = 1'b0; rs1_idx = 5'd7;
    alu_idx = 5'd8; alu_data = 32'h88;
    lsu_vld = 1'b1; lsu_idx = 5'd9; lsu_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tick(3'b000);
      chk("stall_vld", 32'(wr_vld), 1);
      chk("stall_idx", 32'(wr_idx), 7);
      chk("stall_data", wr_data, 32'h77);
      chk("stall_rdy", {29'd0, alu_rdy, lsu_rdy, mdu_rdy}, 0);
      chk("stall_busy", 32'(rs1_busy), 1);
    end
    wr_rdy = 1'b1;
    tick(3'b100);
    alu_vld = 1'b0;
    tick(3'b010);
    lsu_vld = 1'b0;
    tick(3'b000);
    disp_vld = 1'b1; disp_long = 1'b1; disp_rd_idx = 5'd10; rs1_idx = 5'd10; rs2_idx = 5'd10;
    tick(3'b000);
    disp_vld = 1'b0;
    chk("sb_busy1", 32'(rs1_busy), 1);
    tick(3'b000);
    chk("sb_busy2", 32'(rs2_busy), 1);
    lsu_vld = 1'b1; lsu_idx = 5'd10; lsu_data = 32'h1010;
    tick(3'b010);
    lsu_vld = 1'b0;
    chk("sb_busy_outreg", 32'(rs1_busy), 1);
    tick(3'b000);
    chk("sb_cleared", 32'(rs1_busy), 0);
    disp_vld = 1'b1;
    tick(3'b000);
    disp_vld = 1'b0; lsu_vld = 1'b1; lsu_data = 32'h2020;
    tick(3'b010);
    lsu_vld = 1'b0; disp_vld = 1'b1;
    tick(3'b000);
    disp_vld = 1'b0;
    chk("set_wins_rs1", 32'(rs1_busy), 1);
    chk("set_wins_rs2", 32'(rs2_busy), 1);
    lsu_vld = 1'b1; lsu_data = 32'h3030;
    tick(3'b010);
    lsu_vld = 1'b0;
    tick(3'b000);
    chk("sb_cleared2", 32'(rs1_busy), 0);
    mdu_vld = 1'b1; mdu_idx = 5'd0; mdu_data = 32'hDEAD; rs1_idx = 5'd0;
    tick(3'b001);
    mdu_vld = 1'b0;
    chk("x0_no_write", 32'(wr_vld), 0);
    chk("x0_busy", 32'(rs1_busy), 0);
    chk("all_drained", q.size(), 0);
    disp_vld = 1'b1; disp_rd_idx = 5'd3;
    tick(3'b000);
    disp_vld = 1'b0; alu_vld = 1'b1; alu_idx = 5'd4; alu_data = 32'h4444;
    tick(3'b100);
    alu_vld = 1'b0; wr_rdy = 1'b0; rs1_idx = 5'd3;
    #1;
    chk("pre_rst_busy", 32'(rs1_busy), 1);
    chk("pre_rst_vld", 32'(wr_vld), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_vld", 32'(wr_vld), 0);
    chk("async_rst_busy", 32'(rs1_busy), 0);
    chk("async_rst_idx", 32'(wr_idx), 0);
    q.delete();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
